// File: rtl/song_rom_pkg.sv
// Shared types and helpers for the song ROM byte reader.
package song_rom_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FILL} rom_rd_state_t;

    // Mid-scale DAC code played whenever no valid sample exists.
    localparam logic [7:0] SILENCE_LEVEL = 8'h80;

    // Little-endian byte lane pick: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] sel;
        sel = word[7:0];
        case (lane)
            2'd0: sel = word[7:0];
            2'd1: sel = word[15:8];
            2'd2: sel = word[23:16];
            2'd3: sel = word[31:24];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/song_rom_byte_reader_if.sv
// Word-read bus between the byte reader (master) and the on-chip song ROM (slave).
interface song_rom_byte_reader_if #(
    parameter int unsigned ROM_ADDR_W = 12
);
    logic [ROM_ADDR_W-1:0] romAddress;
    logic                  romReadEnable;
    logic [31:0]           romWordData;

    modport master (output romAddress, output romReadEnable, input romWordData);
    modport slave  (input romAddress, input romReadEnable, output romWordData);
endinterface

// File: rtl/rom_read_delay.sv
// Tracks an outstanding ROM read: a strobe enters a DEPTH-stage valid pipe and
// leaves as fill_pulse in the clock just before the ROM word becomes valid.
module rom_read_delay #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clock_50Mhz,
    input  logic reset_n,
    input  logic strobe,
    output logic fill_pulse
);
    logic [DEPTH-1:0] shift_q;

    // Valid shift register; reset discards any read in flight.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= DEPTH'({shift_q, strobe});
        end
    end

    assign fill_pulse = shift_q[DEPTH-1];

endmodule

// File: rtl/song_rom_byte_reader.sv
// Turns the playback byte index into reads of the 32-bit song ROM and returns the
// addressed 8-bit sample, caching one ROM word. Out-of-range indices play silence.
// Optional: define SONG_ROM_PREFETCH_EN to add a second word buffer that is
// prefetched while playback sits on lane 3 of the cached word.
module song_rom_byte_reader
    import song_rom_pkg::*;
#(
    parameter int unsigned ROM_ADDR_W  = 12,
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic                   clock_50Mhz,
    input  logic                   reset_n,
    input  logic [31:0]            byteIndex,
    input  logic [31:0]            byteIndexMax,
    song_rom_byte_reader_if.master rom,
    output logic [7:0]             byteData,
    output logic                   byteValid,
    output logic                   outOfRange
);
    rom_rd_state_t         state_q, state_d;
    logic [ROM_ADDR_W-1:0] idx_addr_c;
    logic [1:0]            lane_c;
    logic                  out_of_range_c;
    logic                  main_hit_c;
    logic                  serve_c;
    logic                  issue_c;
    logic                  fill_c;
    logic                  fill_pulse;
    logic [ROM_ADDR_W-1:0] issue_addr_c;
    logic [7:0]            byte_data_d;
    logic                  byte_valid_d;
    logic                  oor_d;

    logic [31:0]           cache_word_q;
    logic [ROM_ADDR_W-1:0] cache_tag_q;
    logic                  cache_valid_q;

`ifdef SONG_ROM_PREFETCH_EN
    logic [31:0]           pf_word_q;
    logic [ROM_ADDR_W-1:0] pf_tag_q;
    logic                  pf_valid_q;
    logic                  fetch_pf_q;
    logic [ROM_ADDR_W-1:0] next_tag_c;
    logic                  pf_hit_c;
    logic                  pf_wanted_c;
    logic                  issue_pf_c;
    logic                  swap_c;

    assign next_tag_c  = cache_tag_q + ROM_ADDR_W'(1);
    assign pf_hit_c    = pf_valid_q && (pf_tag_q == idx_addr_c);
    assign pf_wanted_c = (lane_c == 2'd3) && !(pf_valid_q && (pf_tag_q == next_tag_c));
`endif

    // Index decode: upper index bits wrap for addressing but still count for range.
    assign idx_addr_c     = byteIndex[ROM_ADDR_W+1:2];
    assign lane_c         = byteIndex[1:0];
    assign out_of_range_c = byteIndex > byteIndexMax;
    assign main_hit_c     = cache_valid_q && (cache_tag_q == idx_addr_c);

    rom_read_delay #(.DEPTH(ROM_LATENCY)) u_delay (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .strobe      (issue_c),
        .fill_pulse  (fill_pulse)
    );

    // State register.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, fetch control and next output values.
    always_comb begin
        state_d      = state_q;
        issue_c      = 1'b0;
        fill_c       = 1'b0;
        issue_addr_c = idx_addr_c;
        byte_data_d  = byteData;
        byte_valid_d = byteValid;
        oor_d        = outOfRange;
`ifdef SONG_ROM_PREFETCH_EN
        issue_pf_c   = 1'b0;
        swap_c       = 1'b0;
        serve_c      = (state_q == IDLE) || fetch_pf_q;
`else
        serve_c      = (state_q == IDLE);
`endif
        if (serve_c) begin
            if (out_of_range_c) begin
                byte_data_d  = SILENCE_LEVEL;
                byte_valid_d = 1'b1;
                oor_d        = 1'b1;
            end else if (main_hit_c) begin
                byte_data_d  = lane_select(cache_word_q, lane_c);
                byte_valid_d = 1'b1;
                oor_d        = 1'b0;
`ifdef SONG_ROM_PREFETCH_EN
                if ((state_q == IDLE) && pf_wanted_c) begin
                    issue_c      = 1'b1;
                    issue_pf_c   = 1'b1;
                    issue_addr_c = next_tag_c;
                end
`endif
            end
`ifdef SONG_ROM_PREFETCH_EN
            else if ((state_q == IDLE) && pf_hit_c) begin
                swap_c       = 1'b1;
                byte_data_d  = lane_select(pf_word_q, lane_c);
                byte_valid_d = 1'b1;
                oor_d        = 1'b0;
            end
`endif
            else begin
                byte_valid_d = 1'b0;
                oor_d        = 1'b0;
                issue_c      = (state_q == IDLE);
            end
        end
        case (state_q)
            IDLE:    if (issue_c) state_d = ISSUE;
            ISSUE:   state_d = fill_pulse ? FILL : WAIT;
            WAIT:    if (fill_pulse) state_d = FILL;
            FILL: begin
                fill_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered sample outputs; byteData only moves when a new value is valid.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            byteData   <= SILENCE_LEVEL;
            byteValid  <= 1'b0;
            outOfRange <= 1'b0;
        end else begin
            byteData   <= byte_data_d;
            byteValid  <= byte_valid_d;
            outOfRange <= oor_d;
        end
    end

    // ROM strobe/address and word buffers.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            rom.romReadEnable <= 1'b0;
            rom.romAddress    <= '0;
            cache_word_q      <= '0;
            cache_tag_q       <= '0;
            cache_valid_q     <= 1'b0;
`ifdef SONG_ROM_PREFETCH_EN
            pf_word_q         <= '0;
            pf_tag_q          <= '0;
            pf_valid_q        <= 1'b0;
            fetch_pf_q        <= 1'b0;
`endif
        end else begin
            rom.romReadEnable <= issue_c;
            if (issue_c) begin
                rom.romAddress <= issue_addr_c;
            end
`ifdef SONG_ROM_PREFETCH_EN
            if (issue_c) begin
                fetch_pf_q <= issue_pf_c;
                if (issue_pf_c) pf_valid_q <= 1'b0;
            end
            if (swap_c) begin
                cache_word_q <= pf_word_q;
                cache_tag_q  <= pf_tag_q;
                pf_word_q    <= cache_word_q;
                pf_tag_q     <= cache_tag_q;
            end
`endif
            if (fill_c) begin
`ifdef SONG_ROM_PREFETCH_EN
                if (fetch_pf_q) begin
                    pf_word_q  <= rom.romWordData;
                    pf_tag_q   <= rom.romAddress;
                    pf_valid_q <= 1'b1;
                end else
`endif
                begin
                    cache_word_q  <= rom.romWordData;
                    cache_tag_q   <= rom.romAddress;
                    cache_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule
